mem_responder: RTL and testbench

- Memory-side responder for the data-cache memory interface (mem_req/mem_we/mem_addr/mem_wdata -> mem_ready/mem_rdata).
- Backs a word array with configurable read/write latency and an external stall input.
- Keeps saturating statistics counters.
- Serves as the main-memory model under the dcache in block and system benches, and as the template for the real memory controller front end.

---
 rtl/mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the data-cache memory interface.
//            Backs a word array with configurable read/write latency, an
//            external stall that freezes the latency countdown, and
//            saturating statistics counters. Requests are served strictly
//            one at a time (IDLE -> WAIT -> RESP -> IDLE).
// Ports    : clk, rst_n        - clock (rising edge), async active-low reset
//            mem_req/we/addr/wdata - request from cache (captured in IDLE)
//            mem_stall         - holds the latency countdown while in WAIT
//            mem_ready         - one-cycle completion pulse
//            mem_rdata         - read data, valid while mem_ready=1
//            busy              - registered (state != IDLE)
//            rd_cnt/wr_cnt     - completed reads/writes, saturating
//            conflict_cnt      - ignored conflicting requests, saturating
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int ADDR_LSB      = 4,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_stall,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    localparam int c_IDX_W   = $clog2(MEM_DEPTH);
    localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // The countdown only ever holds latency-1, so clog2(max) bits suffice.
    localparam int c_LAT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

    localparam logic [c_LAT_W-1:0]   c_RD_LOAD = c_LAT_W'(READ_LATENCY - 1);
    localparam logic [c_LAT_W-1:0]   c_WR_LOAD = c_LAT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state,    w_state_d;
    logic                  r_we,       w_we_d;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addr_d;
    logic [DATA_WIDTH-1:0] r_wdata,    w_wdata_d;
    logic [c_LAT_W-1:0]    r_cnt,      w_cnt_d;
    logic                  r_ready,    w_ready_d;
    logic [DATA_WIDTH-1:0] r_rdata,    w_rdata_d;
    logic                  r_busy,     w_busy_d;
    logic [CNT_WIDTH-1:0]  r_rd_cnt,   w_rd_cnt_d;
    logic [CNT_WIDTH-1:0]  r_wr_cnt,   w_wr_cnt_d;
    logic [CNT_WIDTH-1:0]  r_conf_cnt, w_conf_cnt_d;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_mem_wr;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_conflict;

    // Upper address bits are dropped, so addresses alias modulo the array.
    assign w_idx      = r_addr[ADDR_LSB +: c_IDX_W];
    assign w_conflict = mem_req && ((mem_we != r_we) || (mem_addr != r_addr));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_we_d       = r_we;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_cnt_d      = r_cnt;
        w_ready_d    = 1'b0;
        w_rdata_d    = r_rdata;
        w_rd_cnt_d   = r_rd_cnt;
        w_wr_cnt_d   = r_wr_cnt;
        w_conf_cnt_d = r_conf_cnt;
        w_mem_wr     = 1'b0;

        case (r_state)
            c_IDLE: begin
                // A single-cycle mem_req is enough: the request is posted.
                if (mem_req) begin
                    w_we_d    = mem_we;
                    w_addr_d  = mem_addr;
                    w_wdata_d = mem_wdata;
                    w_cnt_d   = mem_we ? c_WR_LOAD : c_RD_LOAD;
                    w_state_d = c_WAIT;
                end
            end

            c_WAIT: begin
                // A different request presented while busy is dropped, only counted.
                if (w_conflict && (r_conf_cnt != c_CNT_MAX)) begin
                    w_conf_cnt_d = r_conf_cnt + CNT_WIDTH'(1);
                end

                if (!mem_stall) begin
                    if (r_cnt != '0) begin
                        w_cnt_d = r_cnt - c_LAT_W'(1);
                    end else begin
                        w_state_d = c_RESP;
                        w_ready_d = 1'b1;
                        if (r_we) begin
                            w_mem_wr = 1'b1;
                            if (r_wr_cnt != c_CNT_MAX) begin
                                w_wr_cnt_d = r_wr_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            w_rdata_d = r_mem[w_idx];
                            if (r_rd_cnt != c_CNT_MAX) begin
                                w_rd_cnt_d = r_rd_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                end
            end

            // RESP lasts one cycle; mem_req is ignored so a held request
            // is not captured twice.
            c_RESP: begin
                w_state_d = c_IDLE;
            end

            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != c_IDLE);
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_conf_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_we       <= w_we_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_cnt      <= w_cnt_d;
            r_ready    <= w_ready_d;
            r_rdata    <= w_rdata_d;
            r_busy     <= w_busy_d;
            r_rd_cnt   <= w_rd_cnt_d;
            r_wr_cnt   <= w_wr_cnt_d;
            r_conf_cnt <= w_conf_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Word array; cleared by reset so an aborted write leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign mem_ready    = r_ready;
    assign mem_rdata    = r_rdata;
    assign busy         = r_busy;
    assign rd_cnt       = r_rd_cnt;
    assign wr_cnt       = r_wr_cnt;
    assign conflict_cnt = r_conf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder (default
//            latencies, 3-bit counters so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_stall;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] conflict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MEM_DEPTH    (256),
        .ADDR_LSB     (4),
        .READ_LATENCY (3),
        .WRITE_LATENCY(2),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_stall   (mem_stall),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .conflict_cnt(conflict_cnt)
    );

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and pass the capture edge; optionally keep it held.
    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit hold);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        step();
        if (!hold) mem_req = 1'b0;
    endtask

    // Edges after the capture edge until mem_ready is seen; -1 on timeout.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (mem_ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_stall = 1'b0;
        repeat (3) step();
        n_tests++;
        if (mem_ready !== 1'b0 || busy !== 1'b0 || mem_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_out: ready=%b busy=%b rdata=%h, expected 0/0/0", mem_ready, busy, mem_rdata);
        end
        n_tests++;
        if (rd_cnt !== 3'd0 || wr_cnt !== 3'd0 || conflict_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: rd=%0d wr=%0d cf=%0d, expected 0/0/0", rd_cnt, wr_cnt, conflict_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_basic();
        int lat;
        issue(1'b0, 32'h40, '0, 1'b1);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b expected 1", busy); end
        wait_ready(lat);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        n_tests++;
        if (mem_rdata !== 32'h0 || rd_cnt !== 3'd1) begin
            n_fail++; $display("FAIL rd_data_cnt: rdata=%h rd=%0d expected 0/1", mem_rdata, rd_cnt);
        end
        step();
        n_tests++;
        if (mem_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rd_pulse: ready=%b busy=%b expected 0/0", mem_ready, busy);
        end
    endtask

    task automatic test_write_read();
        int lat;
        issue(1'b1, 32'h80, 32'hDEADBEEF, 1'b0);
        wait_ready(lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        n_tests++;
        if (wr_cnt !== 3'd1 || mem_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wr_cnt_rdata: wr=%0d rdata=%h expected 1/0", wr_cnt, mem_rdata);
        end
        step();
        issue(1'b0, 32'h80, '0, 1'b1);
        wait_ready(lat);
        n_tests++;
        if (lat !== 3 || mem_rdata !== 32'hDEADBEEF || rd_cnt !== 3'd2) begin
            n_fail++; $display("FAIL wr_readback: lat=%0d rdata=%h rd=%0d expected 3/deadbeef/2", lat, mem_rdata, rd_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h11;
        step();                       // capture write
        step();                       // WAIT, countdown 1 -> 0
        mem_we = 1'b0; mem_addr = 32'h200;
        step();                       // conflicting read seen, write completes
        n_tests++;
        if (mem_ready !== 1'b1 || conflict_cnt !== 3'd1 || wr_cnt !== 3'd2) begin
            n_fail++; $display("FAIL b2b_wr_done: ready=%b cf=%0d wr=%0d expected 1/1/2", mem_ready, conflict_cnt, wr_cnt);
        end
        step();                       // RESP ends; held request ignored
        n_tests++;
        if (mem_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_resp_end: ready=%b busy=%b expected 0/0", mem_ready, busy);
        end
        step();                       // read captured
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_capture: busy=%b expected 1", busy); end
        wait_ready(lat);
        n_tests++;
        if (lat !== 3 || mem_rdata !== 32'h0 || rd_cnt !== 3'd3 || wr_cnt !== 3'd2) begin
            n_fail++; $display("FAIL b2b_read: lat=%0d rdata=%h rd=%0d wr=%0d expected 3/0/3/2", lat, mem_rdata, rd_cnt, wr_cnt);
        end
        step();
        issue(1'b0, 32'h100, '0, 1'b1);
        wait_ready(lat);
        n_tests++;
        if (mem_rdata !== 32'h11 || rd_cnt !== 3'd4 || conflict_cnt !== 3'd1) begin
            n_fail++; $display("FAIL b2b_wr_data: rdata=%h rd=%0d cf=%0d expected 11/4/1", mem_rdata, rd_cnt, conflict_cnt);
        end
        step();
    endtask

    task automatic test_stall();
        int lat;
        int early = 0;
        issue(1'b0, 32'h80, '0, 1'b1);
        mem_stall = 1'b1;
        repeat (4) begin
            step();
            if (mem_ready !== 1'b0) early++;
        end
        mem_stall = 1'b0;
        n_tests++;
        if (early !== 0) begin n_fail++; $display("FAIL stall_hold: early ready %0d times, expected 0", early); end
        wait_ready(lat);
        n_tests++;
        if (lat + 4 !== 7 || mem_rdata !== 32'hDEADBEEF || rd_cnt !== 3'd5) begin
            n_fail++; $display("FAIL stall_read: total=%0d rdata=%h rd=%0d expected 7/deadbeef/5", lat + 4, mem_rdata, rd_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        issue(1'b1, 32'h300, 32'h55, 1'b0);
        step();                       // still in WAIT, countdown now 0
        n_tests++;
        if (busy !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre: busy=%b ready=%b expected 1/0", busy, mem_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || mem_ready !== 1'b0 || wr_cnt !== 3'd0 || rd_cnt !== 3'd0 || mem_rdata !== '0) begin
            n_fail++; $display("FAIL rst_async: busy=%b ready=%b wr=%0d rd=%0d rdata=%h expected all 0", busy, mem_ready, wr_cnt, rd_cnt, mem_rdata);
        end
        step();
        rst_n = 1'b1;
        issue(1'b0, 32'h300, '0, 1'b1);
        wait_ready(lat);
        n_tests++;
        if (lat !== 3 || mem_rdata !== 32'h0 || wr_cnt !== 3'd0) begin
            n_fail++; $display("FAIL rst_no_commit: lat=%0d rdata=%h wr=%0d expected 3/0/0", lat, mem_rdata, wr_cnt);
        end
        step();
        issue(1'b0, 32'h80, '0, 1'b0);
        wait_ready(lat);
        n_tests++;
        if (mem_rdata !== 32'h0 || rd_cnt !== 3'd2) begin
            n_fail++; $display("FAIL rst_array_clear: rdata=%h rd=%0d expected 0/2", mem_rdata, rd_cnt);
        end
        step();
    endtask

    task automatic test_alias();
        int lat;
        issue(1'b1, 32'h1010, 32'hA5, 1'b0);
        wait_ready(lat);
        step();
        issue(1'b0, 32'h0010, '0, 1'b1);
        wait_ready(lat);
        n_tests++;
        if (mem_rdata !== 32'hA5 || wr_cnt !== 3'd1 || rd_cnt !== 3'd3) begin
            n_fail++; $display("FAIL alias: rdata=%h wr=%0d rd=%0d expected a5/1/3", mem_rdata, wr_cnt, rd_cnt);
        end
        step();
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 32'h0010, '0, 1'b0);
            wait_ready(lat);
            step();
        end
        n_tests++;
        if (rd_cnt !== 3'd7 || wr_cnt !== 3'd1 || mem_rdata !== 32'hA5) begin
            n_fail++; $display("FAIL saturate: rd=%0d wr=%0d rdata=%h expected 7/1/a5", rd_cnt, wr_cnt, mem_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_reset_mid_wait();
        test_alias();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
